load_store_unit: RTL and testbench

Initiator-side controller for the byte-addressed data memory `DataMemory`. It accepts one load/store request at a time from the core over a valid/ready handshake and checks alignment, range and operation legality. It drives the memory's address, data, control and write-enable ports for exactly one access cycle, then returns the load data or completion status over a response handshake with backpressure. It sits between the execute stage and `DataMemory`.

---
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store controller between the execute stage and DataMemory: validates one
// request at a time, drives a single memory access cycle, returns a response.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] DMAddress,
  output logic [31:0] DMDataIn,
  output logic [2:0]  DMCtrl,
  output logic        DMWrEnable,
  input  logic [31:0] DMDataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);
  localparam logic [1:0]  ERR_OK    = 2'b00;
  localparam logic [1:0]  ERR_ALIGN = 2'b01;
  localparam logic [1:0]  ERR_RANGE = 2'b10;
  localparam logic [1:0]  ERR_OP    = 2'b11;
  localparam logic [2:0]  CTRL_WORD = 3'b010;

  state_t      state, state_d;
  logic        req_ready_d, rsp_valid_d, dm_we_d;
  logic [31:0] rsp_rdata_d, dm_addr_d, dm_wdata_d;
  logic [1:0]  rsp_err_d, req_err;
  logic [2:0]  dm_ctrl_d, size_m1;
  logic [32:0] end_addr;
  logic        illegal, misaligned, out_of_range;

  // Request legality in priority order: op, alignment, range (33-bit, no wrap)
  always_comb begin
    size_m1 = 3'd3;
    case (req_op[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
    end_addr     = {1'b0, req_addr} + 33'(size_m1);
    illegal      = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111) ||
                   (req_we && req_op[2]);
    misaligned   = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = end_addr > LAST_ADDR;
    if (illegal)           req_err = ERR_OP;
    else if (misaligned)   req_err = ERR_ALIGN;
    else if (out_of_range) req_err = ERR_RANGE;
    else                   req_err = ERR_OK;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    dm_addr_d   = DMAddress;
    dm_wdata_d  = DMDataIn;
    dm_ctrl_d   = DMCtrl;
    dm_we_d     = DMWrEnable;
    case (state)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          if (req_err != ERR_OK) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d    = ACCESS;
            dm_addr_d  = req_addr;
            dm_wdata_d = req_wdata;
            dm_ctrl_d  = req_op;
            dm_we_d    = req_we;
          end
        end
      end
      ACCESS: begin
        // Load data was presented by the memory at mid-cycle
        state_d     = RESP;
        dm_we_d     = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ERR_OK;
        rsp_rdata_d = DMWrEnable ? 32'd0 : DMDataOut;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        dm_we_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= ERR_OK;
      DMAddress  <= 32'd0;
      DMDataIn   <= 32'd0;
      DMCtrl     <= CTRL_WORD;
      DMWrEnable <= 1'b0;
    end else begin
      state      <= state_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      DMAddress  <= dm_addr_d;
      DMDataIn   <= dm_wdata_d;
      DMCtrl     <= dm_ctrl_d;
      DMWrEnable <= dm_we_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a little-endian DataMemory model
// (writes on rising edge, extended read data on falling edge).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, DMWrEnable;
  logic [2:0]  req_op, DMCtrl;
  logic [31:0] req_addr, req_wdata, rsp_rdata, DMAddress, DMDataIn, DMDataOut;
  logic [1:0]  rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] a0, a1, a2, a3;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DMAddress(DMAddress), .DMDataIn(DMDataIn), .DMCtrl(DMCtrl),
    .DMWrEnable(DMWrEnable), .DMDataOut(DMDataOut)
  );

  always #5 clk = ~clk;

  assign a0 = DMAddress[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;

  always @(posedge clk) begin
    if (DMWrEnable) begin
      mem[a0] <= DMDataIn[7:0];
      if (DMCtrl[1:0] != 2'b00) mem[a1] <= DMDataIn[15:8];
      if (DMCtrl[1:0] == 2'b10) begin
        mem[a2] <= DMDataIn[23:16];
        mem[a3] <= DMDataIn[31:24];
      end
    end
  end

  always @(negedge clk) begin
    case (DMCtrl)
      3'b000:  DMDataOut <= {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  DMDataOut <= {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b010:  DMDataOut <= {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b100:  DMDataOut <= {24'd0, mem[a0]};
      3'b101:  DMDataOut <= {16'd0, mem[a1], mem[a0]};
      default: DMDataOut <= 32'd0;
    endcase
  end

  // One full transaction; lat = cycles from accept cycle to first rsp_valid (99 on timeout)
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic [1:0] err, output int lat, output int wec);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wec = 0;
    while (!rsp_valid && lat < 20) begin
      wec += int'(DMWrEnable);
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = 99;
    wec += int'(DMWrEnable);
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (DMAddress !== 32'd0) begin bad++; $display("FAIL reset_DMAddress got=%h exp=0", DMAddress); end
    total++; if (DMDataIn !== 32'd0) begin bad++; $display("FAIL reset_DMDataIn got=%h exp=0", DMDataIn); end
    total++; if (DMCtrl !== 3'b010) begin bad++; $display("FAIL reset_DMCtrl got=%b exp=010", DMCtrl); end
    total++; if (DMWrEnable !== 1'b0) begin bad++; $display("FAIL reset_DMWrEnable got=%b exp=0", DMWrEnable); end
    total++; if ({rsp_rdata, rsp_err} !== 34'd0) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0/00", rsp_rdata, rsp_err); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic [1:0] er; int lat, wec;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, wec);
    total++; if (wec !== 1) begin bad++; $display("FAIL sw_we_cycles got=%0d exp=1", wec); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    total++; if ({rd, er} !== 34'd0) begin bad++; $display("FAIL sw_rsp got=%h/%b exp=0/00", rd, er); end
    total++; if ({mem[12'h13], mem[12'h12], mem[12'h11], mem[12'h10]} !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_mem got=%h exp=deadbeef", {mem[12'h13], mem[12'h12], mem[12'h11], mem[12'h10]});
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wec);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    total++; if (er !== 2'b00) begin bad++; $display("FAIL lw_err got=%b exp=00", er); end
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (wec !== 0) begin bad++; $display("FAIL lw_we_cycles got=%0d exp=0", wec); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic [1:0] er; int lat, wec;
    do_req(1'b1, 3'b000, 32'h20, 32'h12345680, rd, er, lat, wec);
    total++; if (mem[12'h20] !== 8'h80) begin bad++; $display("FAIL sb_mem got=%h exp=80", mem[12'h20]); end
    do_req(1'b0, 3'b000, 32'h20, 32'h0, rd, er, lat, wec);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", rd); end
    do_req(1'b0, 3'b100, 32'h20, 32'h0, rd, er, lat, wec);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", rd); end
    total++; if (DMCtrl !== 3'b100) begin bad++; $display("FAIL lbu_ctrl got=%b exp=100", DMCtrl); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic [1:0] er; int lat, wec;
    do_req(1'b0, 3'b001, 32'h21, 32'h0, rd, er, lat, wec);
    total++; if (er !== 2'b01) begin bad++; $display("FAIL lh_mis_err got=%b exp=01", er); end
    total++; if (lat !== 1) begin bad++; $display("FAIL lh_mis_latency got=%0d exp=1", lat); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL lh_mis_data got=%h exp=0", rd); end
    do_req(1'b1, 3'b010, 32'h22, 32'hCAFEF00D, rd, er, lat, wec);
    total++; if (er !== 2'b01) begin bad++; $display("FAIL sw_mis_err got=%b exp=01", er); end
    total++; if (wec !== 0) begin bad++; $display("FAIL sw_mis_we got=%0d exp=0", wec); end
    total++; if (DMAddress !== 32'h20) begin bad++; $display("FAIL sw_mis_addr_held got=%h exp=20", DMAddress); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic [1:0] er; int lat, wec;
    do_req(1'b1, 3'b010, 32'hFFC, 32'h44332211, rd, er, lat, wec);
    total++; if (er !== 2'b00) begin bad++; $display("FAIL sw_top_err got=%b exp=00", er); end
    do_req(1'b0, 3'b010, 32'hFFC, 32'h0, rd, er, lat, wec);
    total++; if ({rd, er} !== {32'h44332211, 2'b00}) begin bad++; $display("FAIL lw_top got=%h/%b exp=44332211/00", rd, er); end
    do_req(1'b0, 3'b010, 32'hFFD, 32'h0, rd, er, lat, wec);
    total++; if (er !== 2'b01) begin bad++; $display("FAIL lw_ffd_err got=%b exp=01", er); end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat, wec);
    total++; if (er !== 2'b10) begin bad++; $display("FAIL lw_1000_err got=%b exp=10", er); end
    total++; if (lat !== 1) begin bad++; $display("FAIL lw_1000_latency got=%0d exp=1", lat); end
    do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, rd, er, lat, wec);
    total++; if (er !== 2'b10) begin bad++; $display("FAIL lw_wrap_err got=%b exp=10", er); end
    do_req(1'b0, 3'b101, 32'hFFE, 32'h0, rd, er, lat, wec);
    total++; if ({rd, er} !== {32'h00004433, 2'b00}) begin bad++; $display("FAIL lhu_top got=%h/%b exp=00004433/00", rd, er); end
  endtask

  task automatic test_illegal;
    logic [31:0] rd; logic [1:0] er; int lat, wec;
    do_req(1'b1, 3'b000, 32'h40, 32'hA5, rd, er, lat, wec);
    do_req(1'b1, 3'b100, 32'h40, 32'hFF, rd, er, lat, wec);
    total++; if (er !== 2'b11) begin bad++; $display("FAIL sbu_err got=%b exp=11", er); end
    total++; if (wec !== 0) begin bad++; $display("FAIL sbu_we got=%0d exp=0", wec); end
    total++; if (mem[12'h40] !== 8'hA5) begin bad++; $display("FAIL sbu_mem got=%h exp=a5", mem[12'h40]); end
    do_req(1'b0, 3'b111, 32'h41, 32'h0, rd, er, lat, wec);
    total++; if ({rd, er} !== {32'd0, 2'b11}) begin bad++; $display("FAIL op111_rsp got=%h/%b exp=0/11", rd, er); end
  endtask

  task automatic test_backpressure;
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h50; req_wdata = 32'h1;
      end
      if (i == 2) req_valid = 1'b0;
      total++; if ({rsp_valid, req_ready, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
        bad++; $display("FAIL hold_%0d got=%b/%b/%h exp=1/0/deadbeef", i, rsp_valid, req_ready, rsp_rdata);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL hold_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
    total++; if (DMAddress !== 32'h10) begin bad++; $display("FAIL hold_extra_req got=%h exp=10", DMAddress); end
  endtask

  task automatic test_reset_in_access;
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h30; req_wdata = 32'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (DMWrEnable !== 1'b1) begin bad++; $display("FAIL rst_acc_we got=%b exp=1", DMWrEnable); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (mem[12'h30] !== 8'h5A) begin bad++; $display("FAIL rst_acc_mem got=%h exp=5a", mem[12'h30]); end
    for (int i = 0; i < 3; i++) begin
      total++; if ({rsp_valid, req_ready, DMWrEnable} !== 3'b010) begin
        bad++; $display("FAIL rst_acc_idle_%0d got=%b/%b/%b exp=0/1/0", i, rsp_valid, req_ready, DMWrEnable);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    test_reset;
    test_word;
    test_byte;
    test_misaligned;
    test_range;
    test_illegal;
    test_backpressure;
    test_reset_in_access;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
